v_button_bank: RTL and testbench

V_BUTTON_BANK -- requirements
Module: v_button_bank

---
 rtl/v_button_bank.sv | 118 +++++++++++
 tb/tb_v_button_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/v_button_bank.sv
// Virtual button bank: decodes press/release/tap command chunks into per-button
// held levels with independent tap timers, edge pulses and a saturating error counter.
module v_button_bank #(
  parameter int INTERFACE_RX_CHUNK_TYPE      = 3,
  parameter int RX_CONTENT_BUFFER_BYTE_SIZE  = 3,
  parameter int RX_CONTENT_BUFFER_INDEX_SIZE = 32,
  parameter int NUM_BUTTONS                  = 8,
  parameter int TAP_CYCLES                   = 1000
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic [7:0]                               rx_chunk_type,
  input  logic [RX_CONTENT_BUFFER_BYTE_SIZE*8-1:0] rx_chunk_bytes,
  input  logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0]  rx_chunk_byte_size,
  input  logic                                     rx_is_chunk_ready,
  output logic [NUM_BUTTONS-1:0]                   button_held,
  output logic [NUM_BUTTONS-1:0]                   button_press,
  output logic [NUM_BUTTONS-1:0]                   button_release,
  output logic [7:0]                               button_index,
  output logic                                     event_valid,
  output logic                                     cmd_error,
  output logic [7:0]                               error_count
);

  localparam int TW = $clog2(TAP_CYCLES + 1);
  localparam int IW = RX_CONTENT_BUFFER_INDEX_SIZE;

  localparam logic [1:0] ACT_RELEASE = 2'd0;
  localparam logic [1:0] ACT_PRESS   = 2'd1;
  localparam logic [1:0] ACT_TAP     = 2'd2;

  logic                   ready_prev;
  logic                   sample;
  logic                   type_match;
  logic                   is_size1;
  logic                   is_size2;
  logic                   index_ok;
  logic                   action_ok;
  logic                   cmd_ok;
  logic                   cmd_bad;
  logic [7:0]             byte0;
  logic [7:0]             byte1;
  logic [1:0]             action;
  logic [NUM_BUTTONS-1:0] held_next;

  assign byte0      = rx_chunk_bytes[7:0];
  assign byte1      = rx_chunk_bytes[15:8];
  assign sample     = rx_is_chunk_ready && !ready_prev;
  assign type_match = (rx_chunk_type == 8'(INTERFACE_RX_CHUNK_TYPE));
  assign is_size1   = (rx_chunk_byte_size == IW'(1));
  assign is_size2   = (rx_chunk_byte_size == IW'(2));
  assign index_ok   = ({1'b0, byte0} < 9'(NUM_BUTTONS));
  assign action_ok  = is_size1 || (is_size2 && (byte1 <= 8'h02));
  assign cmd_ok     = sample && type_match && index_ok && action_ok;
  assign cmd_bad    = sample && type_match && !(index_ok && action_ok);
  assign action     = is_size2 ? byte1[1:0] : ACT_TAP;

  generate
    if (RX_CONTENT_BUFFER_BYTE_SIZE > 2) begin : g_spare_bytes
      logic unused_bytes;
      assign unused_bytes = ^rx_chunk_bytes[RX_CONTENT_BUFFER_BYTE_SIZE*8-1:16];
    end
  endgenerate

  // Per-button tap timer; a command on the same button overrides an expiry this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      logic [TW-1:0] timer;
      logic          hit;

      assign hit = cmd_ok && (byte0 == 8'(gi));
      assign held_next[gi] = hit ? (action != ACT_RELEASE)
                           : ((timer == TW'(1)) ? 1'b0 : button_held[gi]);

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          timer <= '0;
        end else if (hit) begin
          timer <= (action == ACT_TAP) ? TW'(TAP_CYCLES) : '0;
        end else if (timer != '0) begin
          timer <= timer - TW'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // Parked high so a ready level that is already asserted never counts as an edge.
      ready_prev     <= 1'b1;
      button_held    <= '0;
      button_press   <= '0;
      button_release <= '0;
      button_index   <= '0;
      event_valid    <= 1'b0;
      cmd_error      <= 1'b0;
      error_count    <= '0;
    end else begin
      ready_prev     <= rx_is_chunk_ready;
      button_held    <= held_next;
      button_press   <= held_next & ~button_held;
      button_release <= ~held_next & button_held;
      event_valid    <= cmd_ok;
      cmd_error      <= cmd_bad;
      if (cmd_ok) begin
        button_index <= byte0;
      end
      if (cmd_bad && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

  logic unused_press_const;
  assign unused_press_const = (ACT_PRESS == 2'd1);

endmodule

// File: tb/tb_v_button_bank.sv
// Directed bench for v_button_bank with TAP_CYCLES=4 and eight buttons.
module tb_v_button_bank;

  logic        CLK;
  logic        RST;
  logic [7:0]  rx_chunk_type;
  logic [23:0] rx_chunk_bytes;
  logic [31:0] rx_chunk_byte_size;
  logic        rx_is_chunk_ready;
  logic [7:0]  button_held;
  logic [7:0]  button_press;
  logic [7:0]  button_release;
  logic [7:0]  button_index;
  logic        event_valid;
  logic        cmd_error;
  logic [7:0]  error_count;

  int n_checks = 0;
  int n_fail   = 0;

  v_button_bank #(
    .INTERFACE_RX_CHUNK_TYPE(3),
    .RX_CONTENT_BUFFER_BYTE_SIZE(3),
    .RX_CONTENT_BUFFER_INDEX_SIZE(32),
    .NUM_BUTTONS(8),
    .TAP_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .rx_chunk_type(rx_chunk_type),
    .rx_chunk_bytes(rx_chunk_bytes),
    .rx_chunk_byte_size(rx_chunk_byte_size),
    .rx_is_chunk_ready(rx_is_chunk_ready),
    .button_held(button_held),
    .button_press(button_press),
    .button_release(button_release),
    .button_index(button_index),
    .event_valid(event_valid),
    .cmd_error(cmd_error),
    .error_count(error_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Present a chunk with a fresh ready edge; returns 1 time unit after the sampling edge.
  task automatic drive(input logic [7:0] typ, input logic [31:0] size,
                       input logic [7:0] b0, input logic [7:0] b1);
    @(negedge CLK);
    rx_chunk_type      = typ;
    rx_chunk_byte_size = size;
    rx_chunk_bytes     = {8'h00, b1, b0};
    rx_is_chunk_ready  = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    @(negedge CLK);
    rx_is_chunk_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    rx_is_chunk_ready = 1'b0;
    rx_chunk_type = 8'h00;
    rx_chunk_bytes = '0;
    rx_chunk_byte_size = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (button_held !== 8'h00) begin n_fail++; $display("FAIL rst_held got %h exp 00", button_held); end
    n_checks++; if (button_index !== 8'h00) begin n_fail++; $display("FAIL rst_index got %h exp 00", button_index); end
    n_checks++; if (error_count !== 8'h00) begin n_fail++; $display("FAIL rst_errcnt got %h exp 00", error_count); end
    n_checks++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL rst_event got %b exp 0", event_valid); end
    @(negedge CLK);
    RST = 1'b0;
    $display("reset done");
  endtask

  task automatic test_press_release();
    drive(8'd3, 32'd2, 8'h03, 8'h01);
    $display("press btn3: held=%h press=%h ev=%b idx=%0d", button_held, button_press, event_valid, button_index);
    n_checks++; if (button_held !== 8'h08) begin n_fail++; $display("FAIL pr_held got %h exp 08", button_held); end
    n_checks++; if (button_press !== 8'h08) begin n_fail++; $display("FAIL pr_press got %h exp 08", button_press); end
    n_checks++; if (event_valid !== 1'b1) begin n_fail++; $display("FAIL pr_event got %b exp 1", event_valid); end
    n_checks++; if (button_index !== 8'd3) begin n_fail++; $display("FAIL pr_index got %0d exp 3", button_index); end
    idle();
    @(posedge CLK); #1;
    n_checks++; if (button_press !== 8'h00) begin n_fail++; $display("FAIL pr_press_width got %h exp 00", button_press); end
    n_checks++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL pr_event_width got %b exp 0", event_valid); end
    drive(8'd3, 32'd2, 8'h03, 8'h00);
    $display("release btn3: held=%h release=%h", button_held, button_release);
    n_checks++; if (button_held !== 8'h00) begin n_fail++; $display("FAIL rel_held got %h exp 00", button_held); end
    n_checks++; if (button_release !== 8'h08) begin n_fail++; $display("FAIL rel_pulse got %h exp 08", button_release); end
    idle();
    drive(8'd3, 32'd2, 8'h03, 8'h00);
    $display("redundant release btn3: ev=%b release=%h", event_valid, button_release);
    n_checks++; if (event_valid !== 1'b1) begin n_fail++; $display("FAIL rel2_event got %b exp 1", event_valid); end
    n_checks++; if (button_release !== 8'h00) begin n_fail++; $display("FAIL rel2_pulse got %h exp 00", button_release); end
    idle();
  endtask

  task automatic test_tap();
    drive(8'd3, 32'd1, 8'h05, 8'h00);
    $display("tap btn5: held=%h press=%h", button_held, button_press);
    n_checks++; if (button_held !== 8'h20) begin n_fail++; $display("FAIL tap_held got %h exp 20", button_held); end
    n_checks++; if (button_press !== 8'h20) begin n_fail++; $display("FAIL tap_press got %h exp 20", button_press); end
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      n_checks++; if (button_held !== ((k < 4) ? 8'h20 : 8'h00)) begin n_fail++; $display("FAIL tap_held_c%0d got %h", k, button_held); end
      n_checks++; if (button_release !== ((k == 4) ? 8'h20 : 8'h00)) begin n_fail++; $display("FAIL tap_rel_c%0d got %h", k, button_release); end
    end
    $display("tap btn5 expired: held=%h", button_held);
  endtask

  task automatic test_retap();
    drive(8'd3, 32'd1, 8'h05, 8'h00);
    idle();
    @(posedge CLK);
    drive(8'd3, 32'd1, 8'h05, 8'h00);
    $display("retap btn5: held=%h press=%h ev=%b", button_held, button_press, event_valid);
    n_checks++; if (button_press !== 8'h00) begin n_fail++; $display("FAIL retap_press got %h exp 00", button_press); end
    n_checks++; if (event_valid !== 1'b1) begin n_fail++; $display("FAIL retap_event got %b exp 1", event_valid); end
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      n_checks++; if (button_held !== ((k < 4) ? 8'h20 : 8'h00)) begin n_fail++; $display("FAIL retap_held_c%0d got %h", k, button_held); end
    end
  endtask

  task automatic test_cmd_beats_expiry();
    drive(8'd3, 32'd1, 8'h06, 8'h00);
    idle();
    repeat (3) @(posedge CLK);
    drive(8'd3, 32'd2, 8'h06, 8'h01);
    $display("press btn6 on expiry edge: held=%h release=%h", button_held, button_release);
    n_checks++; if (button_held !== 8'h40) begin n_fail++; $display("FAIL win_held got %h exp 40", button_held); end
    n_checks++; if (button_release !== 8'h00) begin n_fail++; $display("FAIL win_release got %h exp 00", button_release); end
    idle();
    repeat (6) @(posedge CLK);
    #1;
    n_checks++; if (button_held !== 8'h40) begin n_fail++; $display("FAIL win_hold got %h exp 40", button_held); end
    drive(8'd3, 32'd2, 8'h06, 8'h00);
    idle();
  endtask

  task automatic test_errors();
    drive(8'd3, 32'd2, 8'h02, 8'h01);
    idle();
    drive(8'd3, 32'd2, 8'h08, 8'h01);
    $display("bad index: err=%b ev=%b held=%h", cmd_error, event_valid, button_held);
    n_checks++; if (cmd_error !== 1'b1) begin n_fail++; $display("FAIL err_index got %b exp 1", cmd_error); end
    n_checks++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL err_index_ev got %b exp 0", event_valid); end
    idle();
    drive(8'd3, 32'd2, 8'h02, 8'h07);
    $display("bad action: err=%b held=%h", cmd_error, button_held);
    n_checks++; if (cmd_error !== 1'b1) begin n_fail++; $display("FAIL err_action got %b exp 1", cmd_error); end
    idle();
    drive(8'd3, 32'd3, 8'h02, 8'h00);
    $display("bad size3: err=%b held=%h cnt=%0d", cmd_error, button_held, error_count);
    n_checks++; if (cmd_error !== 1'b1) begin n_fail++; $display("FAIL err_size3 got %b exp 1", cmd_error); end
    n_checks++; if (error_count !== 8'd3) begin n_fail++; $display("FAIL err_count3 got %0d exp 3", error_count); end
    n_checks++; if (button_held !== 8'h04) begin n_fail++; $display("FAIL err_held got %h exp 04", button_held); end
    idle();
    @(posedge CLK); #1;
    n_checks++; if (cmd_error !== 1'b0) begin n_fail++; $display("FAIL err_width got %b exp 0", cmd_error); end
    drive(8'd3, 32'd0, 8'h01, 8'h00);
    n_checks++; if (error_count !== 8'd4) begin n_fail++; $display("FAIL err_size0 got %0d exp 4", error_count); end
    idle();
    for (int i = 0; i < 300; i++) begin
      drive(8'd3, 32'd2, 8'hFF, 8'h01);
      idle();
    end
    $display("after 304 errors: cnt=%0d err=%b", error_count, cmd_error);
    n_checks++; if (error_count !== 8'd255) begin n_fail++; $display("FAIL err_saturate got %0d exp 255", error_count); end
    drive(8'd3, 32'd2, 8'h02, 8'h00);
    idle();
  endtask

  task automatic test_ready_held_and_type();
    int ev_cnt;
    logic [7:0] snap_held;
    drive(8'd3, 32'd2, 8'h04, 8'h01);
    ev_cnt = int'(event_valid);
    for (int k = 0; k < 9; k++) begin
      @(posedge CLK); #1;
      ev_cnt += int'(event_valid);
    end
    $display("ready held 10 cycles: events=%0d held=%h", ev_cnt, button_held);
    n_checks++; if (ev_cnt !== 1) begin n_fail++; $display("FAIL held_ready_events got %0d exp 1", ev_cnt); end
    n_checks++; if (button_held !== 8'h10) begin n_fail++; $display("FAIL held_ready_held got %h exp 10", button_held); end
    idle();
    snap_held = button_held;
    drive(8'd4, 32'd2, 8'h00, 8'h01);
    $display("wrong type: held=%h ev=%b err=%b idx=%0d", button_held, event_valid, cmd_error, button_index);
    n_checks++; if (button_held !== snap_held) begin n_fail++; $display("FAIL type_held got %h exp %h", button_held, snap_held); end
    n_checks++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL type_event got %b exp 0", event_valid); end
    n_checks++; if (cmd_error !== 1'b0) begin n_fail++; $display("FAIL type_error got %b exp 0", cmd_error); end
    n_checks++; if (button_press !== 8'h00) begin n_fail++; $display("FAIL type_press got %h exp 00", button_press); end
    n_checks++; if (button_index !== 8'd4) begin n_fail++; $display("FAIL type_index got %0d exp 4", button_index); end
    n_checks++; if (error_count !== 8'd255) begin n_fail++; $display("FAIL type_errcnt got %0d exp 255", error_count); end
    idle();
  endtask

  task automatic test_reset_mid_tap();
    drive(8'd3, 32'd1, 8'h01, 8'h00);
    n_checks++; if (button_held[1] !== 1'b1) begin n_fail++; $display("FAIL mid_tap_held got %b exp 1", button_held[1]); end
    idle();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    $display("async reset mid-tap: held=%h cnt=%0d", button_held, error_count);
    n_checks++; if (button_held !== 8'h00) begin n_fail++; $display("FAIL arst_held got %h exp 00", button_held); end
    n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL arst_errcnt got %0d exp 0", error_count); end
    rx_chunk_type      = 8'd3;
    rx_chunk_byte_size = 32'd2;
    rx_chunk_bytes     = {8'h00, 8'h01, 8'h07};
    rx_is_chunk_ready  = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      n_checks++; if (button_release !== 8'h00) begin n_fail++; $display("FAIL arst_release_c%0d got %h", k, button_release); end
      n_checks++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale_ready_c%0d got %b", k, event_valid); end
    end
    idle();
    drive(8'd3, 32'd2, 8'h07, 8'h01);
    $display("press btn7 after reset: held=%h ev=%b", button_held, event_valid);
    n_checks++; if (button_held !== 8'h80) begin n_fail++; $display("FAIL arst_rearm got %h exp 80", button_held); end
    idle();
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_tap();
    test_retap();
    test_cmd_beats_expiry();
    test_errors();
    test_ready_held_and_type();
    test_reset_mid_tap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
